// File: rtl/tile_writeback_dma.sv
// tile_writeback_dma: AXI4 write-back engine streaming a computed output tile from the on-chip buffer to DDR
// Ports:
//   start/mode/base_addr/row_len/col_len/line_stride/bank_stride/num_banks/is_final/irq_en : per-tile config, latched on start
//   busy/done/irq/err          : status (done 1-cycle pulse, irq registered, err sticky until next start)
//   buf_rd_en/buf_bank/buf_x/buf_y/buf_rdata : output-buffer read port, data one cycle after buf_rd_en
//   m_axi_aw*/m_axi_w*/m_axi_b* : AXI4 write address, data and response channels
// Optional: define WB_PERF_CNT_EN to add perf_stall_cyc and perf_beats counters.
module tile_writeback_dma #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int DIM_W = 16,
  parameter int MAX_BANKS = 4,
  parameter int MAX_BURST = 256,
  parameter int BOUNDARY = 4096,
  parameter int MAX_OUTST = 8,
  localparam int BYTES = DATA_W / 8,
  localparam int BW = MAX_BANKS > 1 ? $clog2(MAX_BANKS) : 1,
  localparam int NBW = $clog2(MAX_BANKS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  row_len,
  input  logic [DIM_W-1:0]  col_len,
  input  logic [DIM_W-1:0]  line_stride,
  input  logic [DIM_W-1:0]  bank_stride,
  input  logic [NBW-1:0]    num_banks,
  input  logic              is_final,
  input  logic              irq_en,
  output logic              busy,
  output logic              done,
  output logic              irq,
  output logic              err,
  output logic              buf_rd_en,
  output logic [BW-1:0]     buf_bank,
  output logic [DIM_W-1:0]  buf_x,
  output logic [DIM_W-1:0]  buf_y,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [BYTES-1:0]  m_axi_wstrb,
  output logic              m_axi_wlast,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_beats
`endif
);
  localparam int LW = $clog2(MAX_BURST + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int OFFW = $clog2(BOUNDARY);
  typedef enum logic [2:0] {IDLE, CFG, AW, W, NEXT, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] base_r, cur_addr, beat_off;
  logic [DIM_W-1:0] rl_r, cl_r, ls_r, bs_r, r_len, c_len, x, y, ra, ca;
  logic [NBW-1:0] nb_r, b;
  logic [1:0] mode_r;
  logic fin_r, ien_r;
  logic [LW-1:0] len, rd_cnt, wr_cnt, blen;
  logic [DATA_W-1:0] mem [2];
  logic rp, wp, inflight;
  logic [1:0] cnt;
  logic [OW-1:0] outst;
  logic [31:0] left, bnd, lmin;
  logic aw_hs, w_hs, b_hs, row_end, last_row, last_bank, fin;
  always_comb begin
    ra = mode_r == 2'd1 ? rl_r >> 1 : mode_r == 2'd2 ? rl_r << 1 : rl_r;
    ca = mode_r == 2'd1 ? cl_r >> 1 : mode_r == 2'd2 ? cl_r << 1 : cl_r;
    beat_off = ADDR_W'(b) * ADDR_W'(bs_r) + ADDR_W'(y) * ADDR_W'(ls_r) + ADDR_W'(x);
    cur_addr = base_r + beat_off * ADDR_W'(BYTES);
    left = 32'(r_len) - 32'(x);
    // beats remaining before the next boundary, so no burst straddles it
    bnd = (32'(BOUNDARY) - 32'(cur_addr[OFFW-1:0])) / 32'(BYTES);
    lmin = left < bnd ? left : bnd;
    blen = LW'(lmin < 32'(MAX_BURST) ? lmin : 32'(MAX_BURST));
    row_end = 32'(x) + 32'(len) >= 32'(r_len);
    last_row = 32'(y) + 32'd1 == 32'(c_len);
    last_bank = 32'(b) + 32'd1 == 32'(nb_r);
    fin = row_end && last_row && last_bank;
    aw_hs = m_axi_awvalid && m_axi_awready;
    w_hs = m_axi_wvalid && m_axi_wready;
    b_hs = m_axi_bvalid && m_axi_bready;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CFG : IDLE;
      CFG:     state_nx = (ra == '0 || ca == '0 || nb_r == '0) ? DONE : AW;
      AW:      state_nx = aw_hs ? W : AW;
      W:       state_nx = (w_hs && m_axi_wlast) ? NEXT : W;
      NEXT:    state_nx = fin ? DRAIN : AW;
      DRAIN:   state_nx = outst == '0 ? DONE : DRAIN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    m_axi_bready = busy;
    m_axi_awvalid = state == AW && outst != OW'(MAX_OUTST);
    m_axi_awaddr = state == AW ? cur_addr : '0;
    m_axi_awlen = state == AW ? 8'(blen - LW'(1)) : '0;
    m_axi_wvalid = cnt != 2'd0;
    m_axi_wdata = mem[rp];
    m_axi_wlast = m_axi_wvalid && wr_cnt == len - LW'(1);
    m_axi_wstrb = m_axi_wvalid ? '1 : '0;
    // issue a read only if the skid buffer will have room when its data lands
    buf_rd_en = state == W && rd_cnt != len && 3'(cnt) + 3'(inflight) < 3'd2 + 3'(w_hs);
    buf_bank = BW'(b);
    buf_x = x + DIM_W'(rd_cnt);
    buf_y = y;
  end
  always_ff @(posedge clk)
    if (rst) begin
      base_r <= '0;
      rl_r <= '0;
      cl_r <= '0;
      ls_r <= '0;
      bs_r <= '0;
      nb_r <= '0;
      mode_r <= '0;
      fin_r <= 1'b0;
      ien_r <= 1'b0;
      r_len <= '0;
      c_len <= '0;
      x <= '0;
      y <= '0;
      b <= '0;
      len <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      inflight <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      rp <= 1'b0;
      wp <= 1'b0;
      cnt <= '0;
      outst <= '0;
      err <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        base_r <= base_addr;
        rl_r <= row_len;
        cl_r <= col_len;
        ls_r <= line_stride;
        bs_r <= bank_stride;
        nb_r <= num_banks;
        mode_r <= mode;
        fin_r <= is_final;
        ien_r <= irq_en;
        err <= 1'b0;
      end
      if (state == CFG) begin
        r_len <= ra;
        c_len <= ca;
        x <= '0;
        y <= '0;
        b <= '0;
      end
      if (aw_hs) begin
        len <= blen;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (buf_rd_en) rd_cnt <= rd_cnt + LW'(1);
      inflight <= buf_rd_en;
      if (inflight) begin
        mem[wp] <= buf_rdata;
        wp <= ~wp;
      end
      if (w_hs) begin
        rp <= ~rp;
        wr_cnt <= wr_cnt + LW'(1);
      end
      cnt <= cnt + 2'(inflight) - 2'(w_hs);
      if (state == NEXT) begin
        x <= row_end ? '0 : x + DIM_W'(len);
        y <= row_end ? (last_row ? '0 : y + 1'b1) : y;
        b <= (row_end && last_row) ? b + 1'b1 : b;
      end
      outst <= outst + OW'(aw_hs) - OW'(b_hs);
      if (b_hs && m_axi_bresp != 2'b00) err <= 1'b1;
      irq <= done && fin_r && ien_r;
    end
`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk)
    if (rst || (state == IDLE && start)) begin
      perf_stall_cyc <= '0;
      perf_beats <= '0;
    end else begin
      if (busy && ((m_axi_wvalid && !m_axi_wready) || (m_axi_awvalid && !m_axi_awready)))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (w_hs) perf_beats <= perf_beats + 32'd1;
    end
`endif
endmodule

// File: tb/tb_tile_writeback_dma.sv
// tb_tile_writeback_dma: directed self-checking bench for tile_writeback_dma
module tb_tile_writeback_dma;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, is_final, irq_en;
  logic [1:0] mode;
  logic [31:0] base_addr;
  logic [15:0] row_len, col_len, line_stride, bank_stride;
  logic [2:0] num_banks;
  logic busy, done, irq, err, buf_rd_en;
  logic [1:0] buf_bank;
  logic [15:0] buf_x, buf_y;
  logic [127:0] buf_rdata;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [127:0] wdata;
  logic [15:0] wstrb;
  logic [1:0] bresp;
  tile_writeback_dma dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .row_len(row_len), .col_len(col_len), .line_stride(line_stride), .bank_stride(bank_stride),
    .num_banks(num_banks), .is_final(is_final), .irq_en(irq_en),
    .busy(busy), .done(done), .irq(irq), .err(err),
    .buf_rd_en(buf_rd_en), .buf_bank(buf_bank), .buf_x(buf_x), .buf_y(buf_y), .buf_rdata(buf_rdata),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp)
  );
  int n_cmp = 0, n_err = 0;
  bit thr = 1'b0, b_hold = 1'b0, viol = 1'b0, stab = 1'b0;
  int err_idx = -1, bcnt = 0, pend = 0, aw0 = 0, w0 = 0, bc0 = 0, e_n = 0;
  int mon_out = 0, mon_max = 0, aw_n = 0, wb_n = 0;
  logic [31:0] e_addr [16];
  int e_len [16];
  logic [39:0] aw_log [$];
  logic [128:0] w_log [$];
  logic ps_w = 1'b0, ps_a = 1'b0, pwl = 1'b0;
  logic [127:0] pwd = '0;
  logic [31:0] paa = '0;
  logic [7:0] pal = '0;
  function automatic logic [127:0] pat(input int bk, input int yy, input int xx);
    return {32'(bk), 32'(yy), 32'(xx), 32'hC0DEFEED};
  endfunction
  always @(posedge clk) if (buf_rd_en) buf_rdata <= pat(int'(buf_bank), int'(buf_y), int'(buf_x));
  always @(posedge clk) begin
    awready <= (rst || !thr) ? 1'b1 : 1'($urandom_range(0, 1));
    wready <= (rst || !thr) ? 1'b1 : 1'($urandom_range(0, 1));
  end
  always @(posedge clk)
    if (rst) begin
      bvalid <= 1'b0;
      bresp <= 2'd0;
      pend <= 0;
    end else begin
      pend <= pend + ((wvalid && wready && wlast) ? 1 : 0) - ((bvalid && bready) ? 1 : 0);
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        bcnt <= bcnt + 1;
      end else if (!bvalid && !b_hold && pend != 0) begin
        bvalid <= 1'b1;
        bresp <= (bcnt == err_idx) ? 2'd2 : 2'd0;
      end
    end
  always @(posedge clk)
    if (rst) begin
      mon_out <= 0;
      aw_n <= 0;
      wb_n <= 0;
      ps_w <= 1'b0;
      ps_a <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_log.push_back({awlen, awaddr});
        aw_n <= aw_n + 1;
      end
      if (wvalid && wready) begin
        w_log.push_back({wlast, wdata});
        if (aw_n <= wb_n || wstrb !== 16'hFFFF) viol <= 1'b1;
        if (wlast) wb_n <= wb_n + 1;
      end
      mon_out <= mon_out + ((awvalid && awready) ? 1 : 0) - ((bvalid && bready) ? 1 : 0);
      if (mon_out > mon_max) mon_max <= mon_out;
      if (ps_w && !(wvalid && wdata === pwd && wlast === pwl)) stab <= 1'b1;
      if (ps_a && !(awvalid && awaddr === paa && awlen === pal)) stab <= 1'b1;
      ps_w <= wvalid && !wready;
      pwd <= wdata;
      pwl <= wlast;
      ps_a <= awvalid && !awready;
      paa <= awaddr;
      pal <= awlen;
    end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string t);
    chk({t, "_busy"}, 128'(busy), 128'(0));
    chk({t, "_done"}, 128'(done), 128'(0));
    chk({t, "_irq"}, 128'(irq), 128'(0));
    chk({t, "_err"}, 128'(err), 128'(0));
    chk({t, "_rden"}, 128'(buf_rd_en), 128'(0));
    chk({t, "_bufxy"}, 128'({buf_bank, buf_x, buf_y}), 128'(0));
    chk({t, "_awvalid"}, 128'(awvalid), 128'(0));
    chk({t, "_awaddr"}, 128'({awlen, awaddr}), 128'(0));
    chk({t, "_wvalid"}, 128'({wvalid, wlast, wstrb}), 128'(0));
    chk({t, "_wdata"}, wdata, 128'(0));
    chk({t, "_bready"}, 128'(bready), 128'(0));
  endtask
  task automatic ex(input int i, input logic [31:0] a, input int l);
    e_addr[i] = a;
    e_len[i] = l;
  endtask
  task automatic kick(input logic [1:0] md, input logic [31:0] ba, input int rl, input int cl,
                      input int ls, input int bs, input int nb, input bit fin, input bit ien);
    aw0 = aw_log.size();
    w0 = w_log.size();
    bc0 = bcnt;
    mode = md;
    base_addr = ba;
    row_len = 16'(rl);
    col_len = 16'(cl);
    line_stride = 16'(ls);
    bank_stride = 16'(bs);
    num_banks = 3'(nb);
    is_final = fin;
    irq_en = ien;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string t, input bit exp_irq);
    int k = 0;
    while (!done && k < 4000) begin
      @(posedge clk);
      #1 k++;
    end
    chk({t, "_done"}, 128'(done), 128'(1));
    if (done) begin
      chk({t, "_irq_early"}, 128'(irq), 128'(0));
      @(posedge clk);
      #1;
      chk({t, "_irq"}, 128'(irq), 128'(exp_irq));
      chk({t, "_busy_after"}, 128'(busy), 128'(0));
      chk({t, "_done_pulse"}, 128'(done), 128'(0));
    end
  endtask
  task automatic check_xfer(input string t, input int r, input int c, input int nb);
    bit lm [1024];
    int p = 0, k = 0;
    chk({t, "_aw_n"}, 128'(aw_log.size() - aw0), 128'(e_n));
    chk({t, "_b_n"}, 128'(bcnt - bc0), 128'(e_n));
    for (int i = 0; i < e_n; i++) begin
      if (aw0 + i < aw_log.size()) begin
        chk($sformatf("%s_awaddr%0d", t, i), 128'(aw_log[aw0 + i][31:0]), 128'(e_addr[i]));
        chk($sformatf("%s_awlen%0d", t, i), 128'(aw_log[aw0 + i][39:32]), 128'(e_len[i]));
      end
      p += e_len[i] + 1;
      if (p > 0 && p <= 1024) lm[p - 1] = 1'b1;
    end
    for (int bk = 0; bk < nb; bk++)
      for (int yy = 0; yy < c; yy++)
        for (int xx = 0; xx < r; xx++) begin
          if (w0 + k < w_log.size()) begin
            chk($sformatf("%s_wdata%0d", t, k), w_log[w0 + k][127:0], pat(bk, yy, xx));
            chk($sformatf("%s_wlast%0d", t, k), 128'(w_log[w0 + k][128]), 128'(lm[k]));
          end
          k++;
        end
    chk({t, "_beats"}, 128'(w_log.size() - w0), 128'(k));
  endtask
  initial begin
    int k;
    rst = 1'b1;
    start = 1'b0;
    mode = '0;
    base_addr = '0;
    row_len = '0;
    col_len = '0;
    line_stride = '0;
    bank_stride = '0;
    num_banks = '0;
    is_final = 1'b0;
    irq_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_idle("reset");
    rst = 1'b0;
    @(posedge clk);
    #1 chk_idle("idle");
    e_n = 2; ex(0, 32'h1000, 3); ex(1, 32'h1040, 3);
    kick(2'd0, 32'h1000, 4, 2, 4, 0, 1, 1'b1, 1'b1);
    wait_done("t1", 1'b1);
    check_xfer("t1", 4, 2, 1);
    chk("t1_err", 128'(err), 128'(0));
    e_n = 2; ex(0, 32'h0FC0, 3); ex(1, 32'h1000, 3);
    kick(2'd0, 32'h0FC0, 8, 1, 8, 0, 1, 1'b0, 1'b1);
    wait_done("t2", 1'b0);
    check_xfer("t2", 8, 1, 1);
    thr = 1'b1;
    e_n = 2; ex(0, 32'h0, 255); ex(1, 32'h1000, 43);
    kick(2'd0, 32'h0, 300, 1, 300, 0, 1, 1'b1, 1'b0);
    wait_done("t3", 1'b0);
    check_xfer("t3", 300, 1, 1);
    e_n = 4; ex(0, 32'h2000, 3); ex(1, 32'h2040, 3); ex(2, 32'h2400, 3); ex(3, 32'h2440, 3);
    kick(2'd1, 32'h2000, 8, 4, 4, 64, 2, 1'b1, 1'b1);
    wait_done("t4", 1'b1);
    check_xfer("t4", 4, 2, 2);
    thr = 1'b0;
    e_n = 2; ex(0, 32'h3000, 3); ex(1, 32'h3040, 3);
    kick(2'd2, 32'h3000, 2, 1, 4, 0, 1, 1'b1, 1'b1);
    wait_done("t5", 1'b1);
    check_xfer("t5", 4, 2, 1);
    b_hold = 1'b1;
    e_n = 10;
    for (int i = 0; i < 10; i++) ex(i, 32'h4000 + 32'(i) * 32'h40, 3);
    kick(2'd0, 32'h4000, 4, 10, 4, 0, 1, 1'b1, 1'b1);
    k = 0;
    while (aw_log.size() - aw0 < 8 && k < 500) begin
      @(posedge clk);
      #1 k++;
    end
    repeat (30) @(posedge clk);
    #1;
    chk("t6_aw_held", 128'(aw_log.size() - aw0), 128'(8));
    chk("t6_awvalid_off", 128'(awvalid), 128'(0));
    chk("t6_busy", 128'(busy), 128'(1));
    chk("t6_max_outst", 128'(mon_max), 128'(8));
    base_addr = 32'h9999_0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    err_idx = bcnt + 3;
    b_hold = 1'b0;
    wait_done("t6", 1'b1);
    check_xfer("t6", 4, 10, 1);
    chk("t6_err", 128'(err), 128'(1));
    kick(2'd0, 32'h0, 300, 1, 300, 0, 1, 1'b1, 1'b1);
    chk("t7_err_clear", 128'(err), 128'(0));
    k = 0;
    while (!wvalid && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    chk("t7_in_burst", 128'(wvalid), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1 chk_idle("t7_rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    e_n = 2; ex(0, 32'h1000, 3); ex(1, 32'h1040, 3);
    kick(2'd0, 32'h1000, 4, 2, 4, 0, 1, 1'b1, 1'b1);
    wait_done("t7b", 1'b1);
    check_xfer("t7b", 4, 2, 1);
    kick(2'd0, 32'h5000, 0, 3, 4, 0, 1, 1'b1, 1'b1);
    chk("t8_cfg_busy", 128'(busy), 128'(1));
    chk("t8_cfg_done", 128'(done), 128'(0));
    @(posedge clk);
    #1;
    chk("t8_done", 128'(done), 128'(1));
    chk("t8_awvalid", 128'(awvalid), 128'(0));
    @(posedge clk);
    #1;
    chk("t8_idle", 128'({busy, done}), 128'(0));
    chk("t8_irq", 128'(irq), 128'(1));
    chk("t8_no_aw", 128'(aw_log.size() - aw0), 128'(0));
    e_n = 0;
    kick(2'd0, 32'h6000, 4, 2, 4, 0, 0, 1'b1, 1'b0);
    wait_done("t9", 1'b0);
    check_xfer("t9", 4, 2, 0);
    chk("order_strb", 128'(viol), 128'(0));
    chk("stability", 128'(stab), 128'(0));
    chk("max_outst", 128'(mon_max), 128'(8));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
